cursor_frame_ctrl: RTL and testbench

//  Frame-synchronous controller that sequences user inputs into the VGA display path.

---
 rtl/cursor_frame_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_cursor_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_frame_ctrl.sv
// cursor_frame_ctrl: once per video frame, samples debounced buttons, steps and
// clamps the cursor, resolves the house selection, and detects a wand cast.
// All visible outputs are updated only in the COMMIT cycle, which sits inside
// vertical sync. fsm_state exposes the sequencer state for observation.
module cursor_frame_ctrl #(
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          CURSOR_W     = 16,
  parameter int          CURSOR_H     = 16,
  parameter int          STEP         = 4,
  parameter int          DEBOUNCE_CYC = 500000,
  parameter logic [15:0] IR_THRESH    = 16'h8000,
  parameter int          IR_FRAMES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_vs,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        G,
  input  logic        S,
  input  logic        H,
  input  logic        R,
  input  logic [15:0] ir_in,
  output logic [9:0]  cursor_x,
  output logic [8:0]  cursor_y,
  output logic [1:0]  house,
  output logic        house_valid,
  output logic        cast,
  output logic        frame_tick,
  output logic [1:0]  fsm_state
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int IW = $clog2(IR_FRAMES + 1);
  localparam logic [CW-1:0]      DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [IW-1:0]      IR_LAST = IW'(IR_FRAMES - 1);
  localparam logic [IW-1:0]      IR_SAT  = IW'(IR_FRAMES);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - CURSOR_W);
  localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - CURSOR_H);
  localparam logic [9:0]         X_RST   = 10'((SCREEN_W - CURSOR_W) / 2);
  localparam logic [8:0]         Y_RST   = 9'((SCREEN_H - CURSOR_H) / 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    MOVE   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    vs_q, vs_d;            // [0],[1] synchronizer, [2] previous synced level
  logic          frame_tick_q, frame_tick_d;
  logic [7:0]    raw;                   // {R,H,S,G,right,left,down,up}
  logic [7:0]    stable_q, stable_d;
  logic [CW-1:0] db_cnt_q [8];
  logic [CW-1:0] db_cnt_d [8];
  logic [3:0]    hedge;                 // house rising edges on debounced levels
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    dir_q, dir_d;          // {right,left,down,up} latched in SAMPLE
  logic [IW-1:0] ir_cnt_q, ir_cnt_d;
  logic          cast_arm_q, cast_arm_d;
  logic [9:0]    x_sh_q, x_sh_d;
  logic [8:0]    y_sh_q, y_sh_d;
  logic [9:0]    cursor_x_q, cursor_x_d;
  logic [8:0]    cursor_y_q, cursor_y_d;
  logic [1:0]    house_q, house_d;
  logic          house_valid_q, house_valid_d;
  logic          cast_q, cast_d;
  logic signed [10:0] x_t, y_t;

  assign raw = {R, H, S, G, right, left, down, up};

  // Synchronise vsync, find its falling edge, and debounce every button.
  always_comb begin
    vs_d         = {vs_q[1:0], vga_vs};
    frame_tick_d = vs_q[2] & ~vs_q[1];
    stable_d     = stable_q;
    for (int i = 0; i < 8; i++) begin
      db_cnt_d[i] = '0;
      if (raw[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = raw[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
    hedge = stable_d[7:4] & ~stable_q[7:4];
  end

  // Frame sequencer: SAMPLE inputs, compute clamped MOVE, COMMIT to outputs.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    ir_cnt_d      = ir_cnt_q;
    cast_arm_d    = cast_arm_q;
    x_sh_d        = x_sh_q;
    y_sh_d        = y_sh_q;
    cursor_x_d    = cursor_x_q;
    cursor_y_d    = cursor_y_q;
    house_d       = house_q;
    house_valid_d = house_valid_q;
    cast_d        = 1'b0;
    pend_d        = pend_q | hedge;
    x_t           = signed'({1'b0, cursor_x_q});
    y_t           = signed'({2'b00, cursor_y_q});
    unique case (state_q)
      IDLE: begin
        if (frame_tick_q) state_d = SAMPLE;
      end
      SAMPLE: begin
        dir_d = stable_q[3:0];
        if (ir_in >= IR_THRESH) begin
          if (ir_cnt_q != IR_SAT) ir_cnt_d = ir_cnt_q + IW'(1);
          // Arms only on the frame that brings the run up to IR_FRAMES.
          cast_arm_d = (ir_cnt_q == IR_LAST);
        end else begin
          ir_cnt_d   = '0;
          cast_arm_d = 1'b0;
        end
        state_d = MOVE;
      end
      MOVE: begin
        if (dir_q[0] & ~dir_q[1]) begin
          y_t = y_t - STEP_S;
          if (y_t < 11'sd0) y_t = 11'sd0;
        end else if (dir_q[1] & ~dir_q[0]) begin
          y_t = y_t + STEP_S;
          if (y_t > Y_MAX) y_t = Y_MAX;
        end
        if (dir_q[2] & ~dir_q[3]) begin
          x_t = x_t - STEP_S;
          if (x_t < 11'sd0) x_t = 11'sd0;
        end else if (dir_q[3] & ~dir_q[2]) begin
          x_t = x_t + STEP_S;
          if (x_t > X_MAX) x_t = X_MAX;
        end
        x_sh_d  = x_t[9:0];
        y_sh_d  = y_t[8:0];
        state_d = COMMIT;
      end
      COMMIT: begin
        cursor_x_d = x_sh_q;
        cursor_y_d = y_sh_q;
        // Cast needs a house that was already chosen before this commit.
        cast_d     = cast_arm_q & house_valid_q;
        cast_arm_d = 1'b0;
        if (pend_q != 4'b0000) begin
          house_valid_d = 1'b1;
          if      (pend_q[0]) house_d = 2'd0;
          else if (pend_q[1]) house_d = 2'd1;
          else if (pend_q[2]) house_d = 2'd2;
          else                house_d = 2'd3;
        end
        // Edges arriving in this very cycle belong to the next frame.
        pend_d  = hedge;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; reset wins over every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      vs_q          <= 3'b111;
      frame_tick_q  <= 1'b0;
      stable_q      <= '0;
      db_cnt_q      <= '{default: '0};
      pend_q        <= '0;
      dir_q         <= '0;
      ir_cnt_q      <= '0;
      cast_arm_q    <= 1'b0;
      x_sh_q        <= X_RST;
      y_sh_q        <= Y_RST;
      cursor_x_q    <= X_RST;
      cursor_y_q    <= Y_RST;
      house_q       <= 2'd0;
      house_valid_q <= 1'b0;
      cast_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      frame_tick_q  <= frame_tick_d;
      stable_q      <= stable_d;
      db_cnt_q      <= db_cnt_d;
      pend_q        <= pend_d;
      dir_q         <= dir_d;
      ir_cnt_q      <= ir_cnt_d;
      cast_arm_q    <= cast_arm_d;
      x_sh_q        <= x_sh_d;
      y_sh_q        <= y_sh_d;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      house_q       <= house_d;
      house_valid_q <= house_valid_d;
      cast_q        <= cast_d;
    end
  end

  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign house       = house_q;
  assign house_valid = house_valid_q;
  assign cast        = cast_q;
  assign frame_tick  = frame_tick_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_cursor_frame_ctrl.sv
// tb_cursor_frame_ctrl: frame-level directed and random stimulus for
// cursor_frame_ctrl, checked against a per-frame behavioural model.
module tb_cursor_frame_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        vga_vs;
  logic        up, down, left, right;
  logic        G, S, H, R;
  logic [15:0] ir_in;
  logic [9:0]  cursor_x;
  logic [8:0]  cursor_y;
  logic [1:0]  house;
  logic        house_valid;
  logic        cast;
  logic        frame_tick;
  logic [1:0]  fsm_state;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    fall_cyc = -100;
  int    tick_cnt = 0;
  int    cast_cnt = 0;
  string phase = "init";

  // Reference model state, updated once per frame.
  int m_x, m_y, m_house, m_hv, m_run;

  // Monitor history.
  logic        prev_tick = 1'b0;
  logic        prev_rst = 1'b1;
  logic [21:0] prev_out = '0;
  logic [21:0] cur_out;

  cursor_frame_ctrl #(.DEBOUNCE_CYC(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .vga_vs     (vga_vs),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .G          (G),
    .S          (S),
    .H          (H),
    .R          (R),
    .ir_in      (ir_in),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .house      (house),
    .house_valid(house_valid),
    .cast       (cast),
    .frame_tick (frame_tick),
    .fsm_state  (fsm_state)
  );

  // Clock
  initial begin
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  // Monitor: tick width, and every output change lands in the post-COMMIT slot
  // (vsync drop driven after edge e0 -> outputs visible after edge e7).
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      cur_out = {cursor_x, cursor_y, house, house_valid};
      if (frame_tick === 1'b1) begin
        tick_cnt++;
        check("tick_width", int'(prev_tick), 0);
      end
      if (cast === 1'b1) begin
        cast_cnt++;
        check("cast_slot", cyc - fall_cyc, 8);
      end
      if (!reset && !prev_rst && cur_out !== prev_out)
        check("commit_slot", cyc - fall_cyc, 8);
      prev_tick = frame_tick;
      prev_rst  = reset;
      prev_out  = cur_out;
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset  = 1'b1;
    vga_vs = 1'b1;
    {up, down, left, right, G, S, H, R} = '0;
    ir_in  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    m_x = 312; m_y = 232; m_house = 0; m_hv = 0; m_run = 0;
  endtask

  // One 100-cycle frame: dirs held all frame, glitch bits held 3 cycles,
  // house buttons held hlen cycles, vsync low for cycles 20..29.
  task automatic do_frame(input logic [3:0] dirs, input logic [3:0] glitch,
                          input logic [3:0] hmask, input int hlen,
                          input logic [15:0] ir);
    int t0_tick, t0_cast, exp_cast;
    bit lit;
    t0_tick = tick_cnt;
    t0_cast = cast_cnt;
    @(posedge clock); #1;
    {right, left, down, up} = dirs | glitch;
    {R, H, S, G} = hmask;
    ir_in = ir;
    for (int c = 1; c < 100; c++) begin
      @(posedge clock); #1;
      if (c == 3) {right, left, down, up} = dirs;
      if (c == hlen) {R, H, S, G} = 4'b0000;
      if (c == 20) begin vga_vs = 1'b0; fall_cyc = cyc; end
      if (c == 30) vga_vs = 1'b1;
    end
    // Model
    lit = (ir >= 16'h8000);
    m_run = lit ? m_run + 1 : 0;
    exp_cast = (lit && m_run == 3 && m_hv == 1) ? 1 : 0;
    if (dirs[0] && !dirs[1]) m_y = (m_y - 4 < 0) ? 0 : m_y - 4;
    if (dirs[1] && !dirs[0]) m_y = (m_y + 4 > 464) ? 464 : m_y + 4;
    if (dirs[2] && !dirs[3]) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
    if (dirs[3] && !dirs[2]) m_x = (m_x + 4 > 624) ? 624 : m_x + 4;
    if (hlen >= 4 && hmask != 4'b0000) begin
      m_hv = 1;
      for (int i = 3; i >= 0; i--) if (hmask[i]) m_house = i;
    end
    check("ticks_per_frame", tick_cnt - t0_tick, 1);
    check("cursor_x", int'(cursor_x), m_x);
    check("cursor_y", int'(cursor_y), m_y);
    check("house", int'(house), m_house);
    check("house_valid", int'(house_valid), m_hv);
    check("casts_in_frame", cast_cnt - t0_cast, exp_cast);
  endtask

  initial begin
    int c0;
    reset  = 1'b1;
    vga_vs = 1'b1;
    {up, down, left, right, G, S, H, R} = '0;
    ir_in  = '0;

    // 1: reset values, then hold right 10 frames
    phase = "reset";
    do_reset();
    check("x_rst", int'(cursor_x), 312);
    check("y_rst", int'(cursor_y), 232);
    check("house_rst", int'(house), 0);
    check("hv_rst", int'(house_valid), 0);
    check("cast_rst", int'(cast), 0);
    check("tick_rst", int'(frame_tick), 0);
    check("fsm_rst", int'(fsm_state), 0);
    phase = "right10";
    for (int f = 0; f < 10; f++) do_frame(4'b1000, 4'b0000, 4'b0000, 0, 16'h0000);
    check("x_after_10", int'(cursor_x), 352);
    check("y_after_10", int'(cursor_y), 232);

    // 2: clamp at top and right edge
    phase = "up70";
    do_reset();
    for (int f = 0; f < 70; f++) do_frame(4'b0001, 4'b0000, 4'b0000, 0, 16'h0000);
    check("y_floor", int'(cursor_y), 0);
    phase = "right80";
    for (int f = 0; f < 80; f++) do_frame(4'b1000, 4'b0000, 4'b0000, 0, 16'h0000);
    check("x_ceiling", int'(cursor_x), 624);

    // 3: house arbitration
    phase = "house";
    do_frame(4'b0000, 4'b0000, 4'b1001, 6, 16'h0000);
    check("house_GR", int'(house), 0);
    do_frame(4'b0000, 4'b0000, 4'b0100, 6, 16'h0000);
    check("house_H", int'(house), 2);
    do_frame(4'b0000, 4'b0000, 4'b0010, 3, 16'h0000);

    // 4: glitch and opposing buttons
    phase = "glitch";
    do_reset();
    do_frame(4'b0000, 4'b0010, 4'b0000, 0, 16'h0000);
    check("y_glitch", int'(cursor_y), 232);
    do_frame(4'b0011, 4'b0000, 4'b0000, 0, 16'h0000);
    do_frame(4'b1100, 4'b0000, 4'b0000, 0, 16'h0000);
    check("xy_opposed", int'({cursor_x, cursor_y}), int'({10'd312, 9'd232}));

    // 5: cast detection
    phase = "cast";
    do_frame(4'b0000, 4'b0000, 4'b0010, 6, 16'h0000);
    c0 = cast_cnt;
    for (int f = 0; f < 5; f++) do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'h9000);
    check("one_cast_in_run", cast_cnt - c0, 1);
    do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'h1000);
    do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'h8000);
    do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'hFFFF);
    do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'h8000);
    check("second_cast", cast_cnt - c0, 2);
    do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'h7FFF);
    phase = "cast_no_house";
    do_reset();
    c0 = cast_cnt;
    for (int f = 0; f < 4; f++) do_frame(4'b0000, 4'b0000, 4'b0000, 0, 16'hA000);
    check("no_cast_without_house", cast_cnt - c0, 0);

    // Random frames against the model
    phase = "random";
    for (int f = 0; f < 40; f++) begin
      logic [3:0] d, hm;
      int hl;
      d  = 4'($urandom_range(0, 15));
      hm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      hl = $urandom_range(2, 8);
      do_frame(d, 4'b0000, hm, hl, 16'($urandom_range(0, 65535)));
    end

    // 6: reset during MOVE aborts the commit
    phase = "reset_in_move";
    do_reset();
    for (int f = 0; f < 22; f++) do_frame(4'b1000, 4'b0000, 4'b0000, 0, 16'h0000);
    check("x_400", int'(cursor_x), 400);
    @(posedge clock); #1;
    vga_vs = 1'b0;
    fall_cyc = cyc;
    repeat (5) @(posedge clock);
    #1;
    check("fsm_in_move", int'(fsm_state), 2);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("x_after_abort", int'(cursor_x), 312);
    check("y_after_abort", int'(cursor_y), 232);
    check("fsm_after_abort", int'(fsm_state), 0);
    @(posedge clock); #1 vga_vs = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    m_x = 312; m_y = 232; m_house = 0; m_hv = 0; m_run = 0;
    c0 = tick_cnt;
    repeat (100) @(posedge clock);
    #1;
    check("no_commit_x", int'(cursor_x), 312);
    check("no_tick_idle", tick_cnt - c0, 0);
    do_frame(4'b1000, 4'b0000, 4'b0000, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
